// File: rtl/serial_arith_pkg.sv
`default_nettype none
// ============================================================
// Module   : serial_arith_pkg
// Brief    : State encodings and default width for the serial subtractor
// Revision : 1.0
// ============================================================
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================
// Module   : full_subtractor
// Brief    : One-bit combinational subtractor with borrow in/out
// Revision : 1.0
// ============================================================
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================
// Module   : serial_subtractor
// Brief    : Bit-serial a - b, LSB first, one bit per clock
// Revision : 1.0
// ============================================================
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bin_q, bin_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_bit_diff;
  logic             w_bit_bout;

  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (bin_q),
    .diff (w_bit_diff),
    .bout (w_bit_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    bin_d    = bin_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        diff_d = {w_bit_diff, diff_q[WIDTH-1:1]};
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        bin_d  = w_bit_bout;
        if (cnt_q == CNT_LAST) begin
          borrow_d = w_bit_bout;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      bin_q    <= bin_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule
`default_nettype wire
